// File: rtl/video_dram_arb.sv
// rtl/video_dram_arb.sv - video DRAM read-port arbiter with owner-ID return FIFO
// Optional: define VIDEO_DRAM_ARB_RR_EN for TM/TS round-robin; otherwise fixed vid > tm > ts.
module video_dram_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        slot,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    input  logic        tm_req,
    input  logic [20:0] tm_addr,
    input  logic        ts_req,
    input  logic [20:0] ts_addr,
    input  logic        rd_stb,
    output logic        dram_req,
    output logic [20:0] dram_addr,
    output logic        vid_grant,
    output logic        tm_grant,
    output logic        ts_grant,
    output logic        vid_next,
    output logic        tm_next,
    output logic        ts_next,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] ID_VID = 2'b01;
    localparam logic [1:0] ID_TM  = 2'b10;
    localparam logic [1:0] ID_TS  = 2'b11;

    logic [1:0]    own_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          full;
    logic          empty;
    logic          pick_vid;
    logic          pick_tm;
    logic          pick_ts;
    logic          push;
    logic          pop;
    logic [1:0]    push_id;
    logic [1:0]    head_id;
    logic [20:0]   push_addr;

    // Full is judged on pre-pop occupancy, so a same-cycle pop never frees the slot.
    assign full     = (occ == CW'(DEPTH));
    assign empty    = (occ == '0);
    assign pick_vid = slot && !full && vid_req;

`ifdef VIDEO_DRAM_ARB_RR_EN
    logic rr_ts;

    assign pick_tm = slot && !full && !vid_req && tm_req && !(ts_req && rr_ts);
    assign pick_ts = slot && !full && !vid_req && ts_req && !(tm_req && !rr_ts);

    // Pointer only reacts to TM/TS wins; vid grants and wasted slots leave it alone.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rr_ts <= 1'b0;
        end else if (pick_tm) begin
            rr_ts <= 1'b1;
        end else if (pick_ts) begin
            rr_ts <= 1'b0;
        end
    end
`else
    assign pick_tm = slot && !full && !vid_req && tm_req;
    assign pick_ts = slot && !full && !vid_req && !tm_req && ts_req;
`endif

    assign push    = pick_vid || pick_tm || pick_ts;
    assign pop     = rd_stb && !empty;
    assign head_id = own_mem[rd_ptr];
    assign busy    = (occ != '0);

    always_comb begin
        push_id   = ID_VID;
        push_addr = vid_addr;
        if (pick_tm) begin
            push_id   = ID_TM;
            push_addr = tm_addr;
        end else if (pick_ts) begin
            push_id   = ID_TS;
            push_addr = ts_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            own_mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dram_req  <= 1'b0;
            dram_addr <= '0;
            vid_grant <= 1'b0;
            tm_grant  <= 1'b0;
            ts_grant  <= 1'b0;
            vid_next  <= 1'b0;
            tm_next   <= 1'b0;
            ts_next   <= 1'b0;
            err       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
        end else begin
            dram_req  <= push;
            vid_grant <= pick_vid;
            tm_grant  <= pick_tm;
            ts_grant  <= pick_ts;
            vid_next  <= pop && (head_id == ID_VID);
            tm_next   <= pop && (head_id == ID_TM);
            ts_next   <= pop && (head_id == ID_TS);
            occ       <= occ + CW'(push) - CW'(pop);
            if (push) begin
                dram_addr <= push_addr;
                wr_ptr    <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rd_stb && empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_video_dram_arb.sv
// tb/tb_video_dram_arb.sv - self-checking bench for video_dram_arb (vectors, corner sequences, random vs queue model)
module tb_video_dram_arb;
    localparam int DEPTH = 4;
`ifdef VIDEO_DRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [20:0] VA = 21'h1ABCD;
    localparam logic [20:0] TA = 21'h00123;
    localparam logic [20:0] SA = 21'h1F0F0;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        slot = 1'b0;
    logic        vid_req = 1'b0;
    logic [20:0] vid_addr = '0;
    logic        tm_req = 1'b0;
    logic [20:0] tm_addr = '0;
    logic        ts_req = 1'b0;
    logic [20:0] ts_addr = '0;
    logic        rd_stb = 1'b0;
    logic        dram_req;
    logic [20:0] dram_addr;
    logic        vid_grant, tm_grant, ts_grant;
    logic        vid_next, tm_next, ts_next;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    video_dram_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .res(res), .slot(slot),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .tm_req(tm_req), .tm_addr(tm_addr),
        .ts_req(ts_req), .ts_addr(ts_addr),
        .rd_stb(rd_stb), .dram_req(dram_req), .dram_addr(dram_addr),
        .vid_grant(vid_grant), .tm_grant(tm_grant), .ts_grant(ts_grant),
        .vid_next(vid_next), .tm_next(tm_next), .ts_next(ts_next),
        .busy(busy), .err(err)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference state: outstanding owners in issue order, last TM/TS winner, sticky error.
    int          model_q[$];
    int          last_shared;
    logic [20:0] exp_addr;
    int          exp_err;
    int          exp_grant;
    int          exp_next;

    typedef struct {
        bit          s, v, t, ts, rd;
        int          g, n, b;
        logic [20:0] addr;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int enc(input logic a, input logic b, input logic c);
        case ({a, b, c})
            3'b000:  return 0;
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 7;
        endcase
    endfunction

    task automatic model_step(input bit s, input bit v, input bit t, input bit tsr, input bit rd,
                              input logic [20:0] va, input logic [20:0] ta, input logic [20:0] sa);
        bit full;
        full      = (model_q.size() >= DEPTH);
        exp_grant = 0;
        exp_next  = 0;
        if (rd) begin
            if (model_q.size() > 0) exp_next = model_q.pop_front();
            else exp_err = 1;
        end
        if (s && !full) begin
            if (v) exp_grant = 1;
            else if (t && tsr) exp_grant = (RR && last_shared == 2) ? 3 : 2;
            else if (t) exp_grant = 2;
            else if (tsr) exp_grant = 3;
        end
        if (exp_grant != 0) begin
            model_q.push_back(exp_grant);
            exp_addr = (exp_grant == 1) ? va : (exp_grant == 2) ? ta : sa;
            if (exp_grant != 1) last_shared = exp_grant;
        end
    endtask

    task automatic tick(input bit s, input bit v, input bit t, input bit tsr, input bit rd,
                        input logic [20:0] va, input logic [20:0] ta, input logic [20:0] sa);
        slot = s; vid_req = v; tm_req = t; ts_req = tsr; rd_stb = rd;
        vid_addr = va; tm_addr = ta; ts_addr = sa;
        model_step(s, v, t, tsr, rd, va, ta, sa);
        @(posedge clk);
        #1;
        chk("dram_req", dram_req, int'(exp_grant != 0));
        chk("grant", enc(vid_grant, tm_grant, ts_grant), exp_grant);
        chk("next", enc(vid_next, tm_next, ts_next), exp_next);
        chk("dram_addr", dram_addr, exp_addr);
        chk("busy", busy, int'(model_q.size() != 0));
        chk("err", err, exp_err);
        slot = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b1;
        slot = 1'b0; vid_req = 1'b0; tm_req = 1'b0; ts_req = 1'b0; rd_stb = 1'b0;
        #2;
        chk("rst_dram_req", dram_req, 0);
        chk("rst_grant", enc(vid_grant, tm_grant, ts_grant), 0);
        chk("rst_next", enc(vid_next, tm_next, ts_next), 0);
        chk("rst_dram_addr", dram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        model_q.delete();
        last_shared = 3;
        exp_addr = '0;
        exp_err = 0;
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic add(input bit s, input bit v, input bit t, input bit tsr, input bit rd,
                       input int g, input int n, input int b, input logic [20:0] addr);
        vec_t r;
        r.s = s; r.v = v; r.t = t; r.ts = tsr; r.rd = rd;
        r.g = g; r.n = n; r.b = b; r.addr = addr;
        tbl.push_back(r);
    endtask

    initial begin
        int g2;
        logic [20:0] g2a;
        g2  = RR ? 3 : 2;
        g2a = RR ? SA : TA;

        add(1, 1, 1, 1, 0, 1, 0, 1, VA);
        add(0, 0, 0, 0, 0, 0, 0, 1, VA);
        add(0, 0, 0, 0, 0, 0, 0, 1, VA);
        add(0, 0, 0, 0, 1, 0, 1, 0, VA);
        add(1, 0, 1, 1, 0, 2, 0, 1, TA);
        add(0, 0, 1, 1, 1, 0, 2, 0, TA);
        add(1, 0, 1, 1, 0, g2, 0, 1, g2a);
        add(0, 0, 1, 1, 1, 0, g2, 0, g2a);
        add(1, 0, 1, 1, 0, 2, 0, 1, TA);
        add(0, 0, 1, 1, 1, 0, 2, 0, TA);
        add(1, 0, 1, 1, 0, g2, 0, 1, g2a);
        add(0, 0, 0, 0, 1, 0, g2, 0, g2a);
        add(1, 0, 1, 0, 0, 2, 0, 1, TA);
        add(1, 0, 0, 1, 0, 3, 0, 1, SA);
        add(1, 1, 0, 0, 0, 1, 0, 1, VA);
        add(0, 0, 0, 0, 1, 0, 2, 1, VA);
        add(0, 0, 0, 0, 1, 0, 3, 1, VA);
        add(0, 0, 0, 0, 1, 0, 1, 0, VA);

        #1;
        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].s, tbl[i].v, tbl[i].t, tbl[i].ts, tbl[i].rd, VA, TA, SA);
            chk($sformatf("vec%0d_grant", i), enc(vid_grant, tm_grant, ts_grant), tbl[i].g);
            chk($sformatf("vec%0d_next", i), enc(vid_next, tm_next, ts_next), tbl[i].n);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d_addr", i), dram_addr, tbl[i].addr);
        end

        // Fill to DEPTH, waste a slot, then slot and strobe together while full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 1, 1, 1, 0, VA + 21'(i), TA, SA);
        tick(1, 1, 1, 1, 0, 21'h00077, TA, SA);
        chk("full_no_req", dram_req, 0);
        chk("full_addr_held", dram_addr, VA + 21'(DEPTH - 1));
        chk("full_busy", busy, 1);
        tick(1, 1, 1, 1, 1, 21'h00088, TA, SA);
        chk("full_pop_next", enc(vid_next, tm_next, ts_next), 1);
        chk("full_pop_no_grant", dram_req, 0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick(0, 0, 0, 0, 1, VA, TA, SA);
            chk("drain_vid_next", vid_next, 1);
            chk("drain_busy", busy, int'(i != DEPTH - 2));
        end

        // Strobe on empty FIFO, then async reset with two reads outstanding.
        do_reset();
        tick(0, 0, 0, 0, 1, VA, TA, SA);
        chk("empty_err", err, 1);
        chk("empty_no_next", enc(vid_next, tm_next, ts_next), 0);
        tick(0, 0, 0, 0, 0, VA, TA, SA);
        chk("err_sticky", err, 1);
        tick(1, 0, 1, 0, 0, VA, TA, SA);
        tick(1, 0, 0, 1, 0, VA, TA, SA);
        chk("pre_rst_req", dram_req, 1);
        do_reset();
        tick(0, 0, 0, 0, 0, VA, TA, SA);

        for (int i = 0; i < 3000; i++) begin
            bit s, v, t, tsr, rd;
            if (i == 1500) do_reset();
            s   = ($urandom_range(0, 2) != 0);
            v   = ($urandom_range(0, 3) == 0);
            t   = ($urandom_range(0, 1) == 1);
            tsr = ($urandom_range(0, 1) == 1);
            rd  = (model_q.size() > 0) && ($urandom_range(0, 2) != 0);
            tick(s, v, t, tsr, rd, 21'($urandom), 21'($urandom), 21'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
